uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter, companion to the team's UART receiver.
- Serialises one byte per request as: start bit (0), 8 data bits LSB first, even-parity bit, 1 or 2 stop bits (1). Line idles high.
- Sits between a byte-producing client (host logic or test pattern generator) and the board TX pin or the receiver's serial_in in loopback.

Parameters:
- BASE_FREQ, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 115_200, line bit rate in bits/s. The derived localparam counts_per_bit = BASE_FREQ / BAUDRATE (integer division) must be >= 2.
- STOP_BITS, 1, number of stop bits. Legal values are 1 and 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- tx_start  input  1  transmit request; sampled only in IDLE.
- tx_data  input  8  byte to send; captured in the cycle tx_start is accepted.
- serial_out  output  1  UART line; high when idle.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, serial_out=1, tx_busy=0, tx_done=0.
  - bit counter and clock counter go to 0; the shift register goes to 0.
  - rst dominates all other inputs.
- States: IDLE, START, DATA, PARITY, STOP. Any unused encoding returns to IDLE with serial_out=1.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If tx_start=1: latch tx_data into the shift register, compute parity = XOR of the 8 bits (even parity: total count of 1s across data plus parity is even), clear clock_ctr, go to START.
  - tx_done is 1 only in the first IDLE cycle after STOP; otherwise 0.
- START: serial_out=0 for exactly counts_per_bit cycles, then go to DATA with bit index 0.
- DATA:
  - serial_out = data[idx] for counts_per_bit cycles per bit, idx 0..7.
  - After idx 7 completes, go to PARITY.
- PARITY: serial_out=parity for counts_per_bit cycles, then go to STOP.
- STOP:
  - serial_out=1 for STOP_BITS*counts_per_bit cycles, then go to IDLE.
  - Assert tx_done on that same edge (registered), so tx_done is high for exactly one cycle.
- Output timing:
  - serial_out and tx_busy are registered.
  - The start bit appears on the first edge after the acceptance edge (1-cycle latency).
  - tx_busy=1 exactly while state is not IDLE.
- Frame length: (10+STOP_BITS)*counts_per_bit cycles from the start-bit edge to the IDLE entry edge.
- Back-to-back frames: tx_start=1 during the tx_done cycle is accepted. The next start bit follows the final stop bit with zero extra idle time beyond the 1 acceptance cycle.
- tx_start while tx_busy=1 is ignored. The in-flight frame is unaffected.
- Changes on tx_data after acceptance have no effect on the current frame.
- Reset mid-frame: on the next edge serial_out=1, tx_busy=0, tx_done=0, and the frame is abandoned. No tx_done is issued for the aborted frame.
- clock_ctr is 32 bits and counts 0..counts_per_bit-1. It wraps to 0 at each bit boundary; never free-running.

Test Plan:
- Common setup: BASE_FREQ=1_000_000, BAUDRATE=100_000 (10 cycles/bit), STOP_BITS=1. Sample serial_out at mid-bit.
- Send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity=0, stop). tx_busy is high 110 cycles; one tx_done pulse.
- Send 0x07 -> data bits 1,1,1,0,0,0,0,0 and parity=1. Loop serial_out into uart_rx with the same parameters -> parallel_out=0x07 and no parity_error.
- Send 0x3C and hold tx_start=1 through the whole frame, with tx_data changed to 0xFF mid-frame -> exactly one frame carrying 0x3C. A second frame (0xFF) starts on the tx_done cycle.
- Assert rst for 1 cycle at cycle 45 of a 0x00 frame -> serial_out=1 and tx_busy=0 on the next edge, no tx_done. A new 0x81 request afterward transmits correctly (parity=0).
- STOP_BITS=2, send 0xFF -> parity=0, stop high for 20 cycles, frame 120 cycles, tx_done 120 cycles after the start-bit edge.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, even parity, 1-2 stop bits; line idles high.
// Start bit leaves one cycle after acceptance; tx_start is ignored while a frame is in flight.
module uart_tx #(
    parameter int unsigned BASE_FREQ = 50_000_000,
    parameter int unsigned BAUDRATE  = 115_200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned counts_per_bit = BASE_FREQ / BAUDRATE;
    localparam logic [31:0] last_ctr = 32'(counts_per_bit - 1);
    localparam logic [2:0]  last_stop = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] clock_ctr;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        parity;
    logic        bit_end;

    assign bit_end = (clock_ctr == last_ctr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            clock_ctr  <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                    clock_ctr  <= '0;
                    bit_idx    <= '0;
                    if (tx_start) begin
                        shift_reg <= tx_data;
                        parity    <= ^tx_data;
                        state     <= START;
                    end
                end
                START: begin
                    // First START cycle is the acceptance cycle: drop the line, don't count yet.
                    if (!tx_busy) begin
                        tx_busy    <= 1'b1;
                        serial_out <= 1'b0;
                    end else if (bit_end) begin
                        clock_ctr  <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clock_ctr <= '0;
                        if (bit_idx == 3'd7) begin
                            serial_out <= parity;
                            state      <= PARITY;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            shift_reg  <= {1'b0, shift_reg[7:1]};
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clock_ctr  <= '0;
                        bit_idx    <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                STOP: begin
                    serial_out <= 1'b1;
                    if (bit_end) begin
                        clock_ctr <= '0;
                        if (bit_idx == last_stop) begin
                            bit_idx <= '0;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clock_ctr <= clock_ctr + 32'd1;
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                    clock_ctr  <= '0;
                    bit_idx    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit, one-stop-bit and two-stop-bit instances.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tx_start1, tx_start2;
    logic [7:0] tx_data1, tx_data2;
    logic       so1, so2;
    logic       busy1, busy2;
    logic       done1, done2;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int busy_cnt1 = 0, busy_cnt2 = 0;
    int done_cnt1 = 0, done_cnt2 = 0;
    int done_cyc1 = 0, done_cyc2 = 0;
    int start_cyc1 = 0, start_cyc2 = 0;
    logic busy1_q = 1'b0, busy2_q = 1'b0;

    uart_tx #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_start(tx_start1), .tx_data(tx_data1),
        .serial_out(so1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_start(tx_start2), .tx_data(tx_data2),
        .serial_out(so2), .tx_busy(busy2), .tx_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy1) busy_cnt1++;
        if (busy2) busy_cnt2++;
        if (done1) begin done_cnt1++; done_cyc1 = cyc; end
        if (done2) begin done_cnt2++; done_cyc2 = cyc; end
        if (!busy1_q && busy1) start_cyc1 = cyc;
        if (!busy2_q && busy2) start_cyc2 = cyc;
        busy1_q = busy1;
        busy2_q = busy2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge right after the acceptance edge; samples each bit mid-way.
    task automatic check_frame(input bit sel, input int nbits, input logic [11:0] exp,
                               input logic [7:0] late, input string tag,
                               output logic [11:0] got);
        got = '0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b > 0) repeat (10) @(negedge clk);
            got[b] = sel ? so2 : so1;
            chk($sformatf("%s_bit%0d", tag, b), 32'(got[b]), 32'(exp[b]));
            if (b == 5) begin
                if (sel) tx_data2 = late;
                else     tx_data1 = late;
            end
        end
    endtask

    initial begin
        logic [11:0] got;
        int b0, d0, s0;

        rst = 1'b1;
        tx_start1 = 1'b0; tx_start2 = 1'b0;
        tx_data1 = 8'h00; tx_data2 = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_serial_out", 32'(so1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_serial_out2", 32'(so2), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_serial_out", 32'(so1), 32'd1);

        // 0xA5: parity 0, busy 110 cycles, one done pulse
        tx_data1 = 8'hA5; tx_start1 = 1'b1;
        @(negedge clk);
        tx_start1 = 1'b0;
        b0 = busy_cnt1; d0 = done_cnt1;
        check_frame(1'b0, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 8'h00, "a5", got);
        repeat (10) @(negedge clk);
        chk("a5_busy_cycles", 32'(busy_cnt1 - b0), 32'd110);
        chk("a5_done_pulses", 32'(done_cnt1 - d0), 32'd1);
        chk("a5_frame_len", 32'(done_cyc1 - start_cyc1), 32'd110);
        chk("a5_idle_line", 32'(so1), 32'd1);

        // 0x07: parity 1, decode samples like a receiver
        tx_data1 = 8'h07; tx_start1 = 1'b1;
        @(negedge clk);
        tx_start1 = 1'b0;
        check_frame(1'b0, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 8'hC3, "x07", got);
        chk("x07_rx_byte", 32'(got[8:1]), 32'h07);
        chk("x07_rx_parity_ok", 32'(^got[9:1]), 32'd0);
        repeat (10) @(negedge clk);

        // 0x3C with tx_start held: one frame, then 0xFF accepted on the done cycle
        tx_data1 = 8'h3C; tx_start1 = 1'b1;
        @(negedge clk);
        d0 = done_cnt1;
        check_frame(1'b0, 11, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 8'hFF, "x3c", got);
        repeat (6) @(negedge clk);
        tx_start1 = 1'b0;
        chk("x3c_done_pulses", 32'(done_cnt1 - d0), 32'd1);
        chk("x3c_gap_line", 32'(so1), 32'd1);
        check_frame(1'b0, 11, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 8'h00, "xff_b2b", got);
        repeat (10) @(negedge clk);
        chk("b2b_done_pulses", 32'(done_cnt1 - d0), 32'd2);

        // Reset at cycle 45 of a 0x00 frame
        tx_data1 = 8'h00; tx_start1 = 1'b1;
        @(negedge clk);
        tx_start1 = 1'b0;
        d0 = done_cnt1;
        repeat (44) @(negedge clk);
        chk("abort_pre_line", 32'(so1), 32'd0);
        chk("abort_pre_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_serial_out", 32'(so1), 32'd1);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        repeat (130) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt1 - d0), 32'd0);
        chk("abort_idle_line", 32'(so1), 32'd1);

        // 0x81 after the abort
        tx_data1 = 8'h81; tx_start1 = 1'b1;
        @(negedge clk);
        tx_start1 = 1'b0;
        d0 = done_cnt1;
        check_frame(1'b0, 11, {1'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 8'h00, "x81", got);
        repeat (10) @(negedge clk);
        chk("x81_done_pulses", 32'(done_cnt1 - d0), 32'd1);

        // Two stop bits, 0xFF
        tx_data2 = 8'hFF; tx_start2 = 1'b1;
        @(negedge clk);
        tx_start2 = 1'b0;
        b0 = busy_cnt2; s0 = done_cnt2;
        check_frame(1'b1, 12, {1'b1, 1'b1, 1'b0, 8'hFF, 1'b0}, 8'h00, "sb2", got);
        repeat (10) @(negedge clk);
        chk("sb2_busy_cycles", 32'(busy_cnt2 - b0), 32'd120);
        chk("sb2_done_pulses", 32'(done_cnt2 - s0), 32'd1);
        chk("sb2_frame_len", 32'(done_cyc2 - start_cyc2), 32'd120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
